// File: rtl/i2s_pkg.sv
// Shared constants and types for the i2s mixer scheduler.
package i2s_pkg;
  localparam logic SIDE_LEFT  = 1'b1;
  localparam logic SIDE_RIGHT = 1'b0;

  typedef enum logic {IDLE, PRESENT} sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4,
  parameter int SRCW = $clog2(N)
) (
  input  logic [N-1:0]    elig,
  input  logic [SRCW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SRCW-1:0] grant_idx,
  output logic            any_grant
);
  localparam int unsigned NU = N;

  logic [SRCW-1:0] pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    pos       = '0;
    for (int unsigned k = 1; k <= NU; k++) begin
      pos = SRCW'((32'(ptr) + k) % NU);
      if (!any_grant && elig[pos]) begin
        any_grant  = 1'b1;
        grant[pos] = 1'b1;
        grant_idx  = pos;
      end
    end
  end
endmodule

// File: rtl/i2s_mix_sched.sv
// Shares one mixer sample port among NUM_SOURCES i2sin receivers, grouping
// samples by stereo side with round-robin order inside each side.
module i2s_mix_sched
  import i2s_pkg::*;
#(
  parameter int BITS_PRECISION = 4,
  parameter int NUM_SOURCES = 4,
  localparam int SRCW = $clog2(NUM_SOURCES)
) (
  input  logic                                sck,
  input  logic                                rst,
  input  logic [NUM_SOURCES*BITS_PRECISION-1:0] src_data,
  input  logic [NUM_SOURCES-1:0]              src_lr,
  input  logic [NUM_SOURCES-1:0]              src_en,
  input  logic [NUM_SOURCES-1:0]              src_mask,
  output logic [BITS_PRECISION-1:0]           out_data,
  output logic [SRCW-1:0]                     out_src,
  output logic                                out_lr,
  output logic                                out_first,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_SOURCES-1:0]              overrun,
  input  logic                                ovr_clear
);
  logic [NUM_SOURCES-1:0]    hold_valid, hold_lr;
  logic [BITS_PRECISION-1:0] hold_data [NUM_SOURCES];

  sched_state_t    state;
  logic            cur_side, side_fresh;
  logic [SRCW-1:0] rr_ptr;

  logic [NUM_SOURCES-1:0] same_side, elig_cur, elig_oth, oh_cur, oh_oth, win_oh, new_ovr;
  logic [SRCW-1:0]        idx_cur, idx_oth, win_idx;
  logic                   any_cur, any_oth, can_grant, do_grant, flip;

  always_comb begin
    same_side = cur_side ? hold_lr : ~hold_lr;
    elig_cur  = hold_valid & same_side;
    elig_oth  = hold_valid & ~same_side;
    can_grant = (state == IDLE) || out_ready;
    flip      = !any_cur;
    do_grant  = can_grant && (any_cur || any_oth);
    win_idx   = any_cur ? idx_cur : idx_oth;
    win_oh    = do_grant ? (any_cur ? oh_cur : oh_oth) : '0;
  end

  rr_arbiter #(.N(NUM_SOURCES), .SRCW(SRCW)) u_arb_cur (
    .elig(elig_cur), .ptr(rr_ptr), .grant(oh_cur), .grant_idx(idx_cur), .any_grant(any_cur)
  );

  rr_arbiter #(.N(NUM_SOURCES), .SRCW(SRCW)) u_arb_oth (
    .elig(elig_oth), .ptr(rr_ptr), .grant(oh_oth), .grant_idx(idx_oth), .any_grant(any_oth)
  );

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_hold
    logic                      hv, hl;
    logic [BITS_PRECISION-1:0] hd;

    // A hold that is granted on this edge frees up in time to take a new strobe.
    always_ff @(posedge sck) begin
      if (!rst) begin
        hv <= 1'b0;
        hl <= SIDE_LEFT;
        hd <= '0;
      end else if (!src_mask[g]) begin
        hv <= 1'b0;
      end else if (src_en[g]) begin
        if (!hv || win_oh[g]) begin
          hv <= 1'b1;
          hl <= src_lr[g];
          hd <= src_data[g*BITS_PRECISION +: BITS_PRECISION];
        end
      end else if (win_oh[g]) begin
        hv <= 1'b0;
      end
    end

    assign hold_valid[g] = hv;
    assign hold_lr[g]    = hl;
    assign hold_data[g]  = hd;
    assign new_ovr[g]    = src_mask[g] && src_en[g] && hv && !win_oh[g];
  end

  always_ff @(posedge sck) begin
    if (!rst) overrun <= '0;
    else      overrun <= (ovr_clear ? '0 : overrun) | new_ovr;
  end

  always_ff @(posedge sck) begin
    if (!rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      out_lr     <= SIDE_LEFT;
      out_first  <= 1'b0;
      cur_side   <= SIDE_LEFT;
      side_fresh <= 1'b1;
      rr_ptr     <= SRCW'(NUM_SOURCES - 1);
    end else begin
      case (state)
        IDLE, PRESENT: begin
          if (do_grant) begin
            state      <= PRESENT;
            out_valid  <= 1'b1;
            out_data   <= hold_data[win_idx];
            out_src    <= win_idx;
            out_lr     <= flip ? ~cur_side : cur_side;
            out_first  <= flip || side_fresh;
            side_fresh <= 1'b0;
            rr_ptr     <= win_idx;
            if (flip) cur_side <= ~cur_side;
          end else if (state == PRESENT && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2s_mix_sched.sv
// Randomised and directed checks of i2s_mix_sched against a side-grouping model.
module tb_i2s_mix_sched;
  localparam int N  = 4;
  localparam int BP = 4;
  localparam int SW = 2;
  localparam int TOTW = 1 + BP + SW + 1 + 1 + N;

  logic            sck, rst;
  logic [N*BP-1:0] src_data;
  logic [N-1:0]    src_lr, src_en, src_mask;
  logic [BP-1:0]   out_data;
  logic [SW-1:0]   out_src;
  logic            out_lr, out_first, out_valid, out_ready, ovr_clear;
  logic [N-1:0]    overrun;

  int checks = 0;
  int errors = 0;

  i2s_mix_sched #(.BITS_PRECISION(BP), .NUM_SOURCES(N)) dut (
    .sck(sck), .rst(rst), .src_data(src_data), .src_lr(src_lr), .src_en(src_en),
    .src_mask(src_mask), .out_data(out_data), .out_src(out_src), .out_lr(out_lr),
    .out_first(out_first), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .ovr_clear(ovr_clear)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  // Reference model: per-source mailbox plus "which side was last presented".
  bit            m_hv [N];
  bit            m_hl [N];
  logic [BP-1:0] m_hd [N];
  bit            m_side;
  int            m_ptr;
  int            m_last;
  logic [N-1:0]  m_ov;
  bit            m_valid;
  logic [BP-1:0] m_data;
  int            m_src;
  bit            m_lr, m_first;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_hv[i] = 0;
    m_side = 1; m_ptr = N - 1; m_last = 2; m_ov = '0;
    m_valid = 0; m_data = '0; m_src = 0; m_lr = 1; m_first = 0;
  endtask

  function automatic int pick(bit side);
    for (int k = 1; k <= N; k++) begin
      int j = (m_ptr + k) % N;
      if (m_hv[j] && m_hl[j] == side) return j;
    end
    return -1;
  endfunction

  task automatic model_step();
    int w;
    bit side;
    logic [N-1:0] nov;
    if (!rst) begin
      model_reset();
      return;
    end
    w = -1;
    side = m_side;
    if (!m_valid || out_ready) begin
      w = pick(m_side);
      if (w < 0) begin
        w = pick(!m_side);
        side = !m_side;
      end
      if (w >= 0) begin
        m_valid = 1; m_data = m_hd[w]; m_src = w; m_lr = side;
        m_first = (m_last != int'(side));
        m_last = int'(side); m_side = side; m_ptr = w;
      end else begin
        m_valid = 0;
      end
    end
    nov = '0;
    for (int i = 0; i < N; i++) begin
      if (!src_mask[i]) m_hv[i] = 0;
      else if (src_en[i]) begin
        if (!m_hv[i] || w == i) begin
          m_hv[i] = 1; m_hl[i] = src_lr[i]; m_hd[i] = src_data[i*BP +: BP];
        end else nov[i] = 1'b1;
      end else if (w == i) m_hv[i] = 0;
    end
    m_ov = (ovr_clear ? '0 : m_ov) | nov;
  endtask

  function automatic logic [TOTW-1:0] exp_vec();
    return {m_valid, m_valid ? m_data : BP'(0), m_valid ? SW'(m_src) : SW'(0),
            m_valid && m_lr, m_valid && m_first, m_ov};
  endfunction

  function automatic logic [TOTW-1:0] obs_vec();
    return {out_valid, out_valid ? out_data : BP'(0), out_valid ? out_src : SW'(0),
            out_valid && out_lr, out_valid && out_first, overrun};
  endfunction

  task automatic tick();
    model_step();
    @(posedge sck);
    #1;
  endtask

  task automatic strobe(input int idx, input bit lr, input logic [BP-1:0] d);
    src_en[idx] = 1'b1;
    src_lr[idx] = lr;
    src_data[idx*BP +: BP] = d;
  endtask

  task automatic test_reset();
    rst = 1'b0; src_data = '0; src_lr = '0; src_en = '0; src_mask = '1;
    out_ready = 1'b1; ovr_clear = 1'b0;
    model_reset();
    tick(); tick();
    rst = 1'b1;
    checks++;
    if ({out_valid, out_data, out_src, out_lr, out_first, overrun} !== {1'b0, 4'h0, 2'd0, 1'b1, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h",
               {out_valid, out_data, out_src, out_lr, out_first, overrun},
               {1'b0, 4'h0, 2'd0, 1'b1, 1'b0, 4'h0});
    end
  endtask

  task automatic test_all_left();
    for (int i = 0; i < N; i++) strobe(i, 1'b1, BP'(i + 1));
    tick();
    src_en = '0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL all_left_latency: out_valid got %b expected 0", out_valid);
    end
    tick();
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({out_valid, out_src, out_data, out_lr, out_first} !== {1'b1, SW'(i), BP'(i + 1), 1'b1, i == 0}) begin
        errors++;
        $display("FAIL all_left_seq%0d: got %h expected %h", i,
                 {out_valid, out_src, out_data, out_lr, out_first},
                 {1'b1, SW'(i), BP'(i + 1), 1'b1, i == 0});
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL all_left_model: got %h expected %h", obs_vec(), exp_vec());
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL all_left_drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_flip();
    strobe(0, 1'b0, 4'd5);
    strobe(2, 1'b0, 4'd6);
    tick();
    src_en = '0;
    tick();
    checks++;
    if ({out_valid, out_src, out_data, out_lr, out_first} !== {1'b1, 2'd0, 4'd5, 1'b0, 1'b1}) begin
      errors++; $display("FAIL flip_first: got %h expected %h",
                         {out_valid, out_src, out_data, out_lr, out_first}, {1'b1, 2'd0, 4'd5, 1'b0, 1'b1});
    end
    tick();
    checks++;
    if ({out_valid, out_src, out_data, out_lr, out_first} !== {1'b1, 2'd2, 4'd6, 1'b0, 1'b0}) begin
      errors++; $display("FAIL flip_second: got %h expected %h",
                         {out_valid, out_src, out_data, out_lr, out_first}, {1'b1, 2'd2, 4'd6, 1'b0, 1'b0});
    end
    tick();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL flip_model: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    strobe(1, 1'b1, 4'd7);
    tick();
    src_en = '0;
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c == 0) strobe(1, 1'b1, 4'd8);
      if (c == 2) strobe(1, 1'b1, 4'd9);
      tick();
      src_en = '0;
      checks++;
      if ({out_valid, out_src, out_data, out_lr, out_first} !== {1'b1, 2'd1, 4'd7, 1'b1, 1'b1}) begin
        errors++; $display("FAIL stall_hold%0d: got %h expected %h", c,
                           {out_valid, out_src, out_data, out_lr, out_first}, {1'b1, 2'd1, 4'd7, 1'b1, 1'b1});
      end
    end
    checks++;
    if (overrun !== 4'b0010) begin
      errors++; $display("FAIL stall_overrun: got %b expected 0010", overrun);
    end
    ovr_clear = 1'b1;
    tick();
    ovr_clear = 1'b0;
    checks++;
    if (overrun !== 4'b0000) begin
      errors++; $display("FAIL stall_ovr_clear: got %b expected 0000", overrun);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_src, out_data, out_first} !== {1'b1, 2'd1, 4'd8, 1'b0}) begin
      errors++; $display("FAIL stall_refill: got %h expected %h",
                         {out_valid, out_src, out_data, out_first}, {1'b1, 2'd1, 4'd8, 1'b0});
    end
    tick();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL stall_model: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_mask();
    out_ready = 1'b0;
    strobe(2, 1'b1, 4'd10);
    strobe(3, 1'b1, 4'd11);
    tick();
    src_en = '0;
    tick();
    src_mask[3] = 1'b0;
    tick();
    out_ready = 1'b1;
    strobe(3, 1'b1, 4'd12);
    for (int c = 0; c < 4; c++) begin
      tick();
      src_en = '0;
      checks++;
      if ((out_valid && out_src == 2'd3) || overrun[3] !== 1'b0) begin
        errors++; $display("FAIL mask_src3: got valid=%b src=%0d ovr3=%b expected src3 absent, ovr3=0",
                           out_valid, out_src, overrun[3]);
      end
    end
    src_mask = '1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL mask_dropped: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) strobe(i, 1'b1, BP'(i + 3));
    tick();
    src_en = '0;
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: out_valid got %b expected 1", out_valid);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if ({out_valid, out_data, out_src, out_lr, out_first, overrun} !== {1'b0, 4'h0, 2'd0, 1'b1, 1'b0, 4'h0}) begin
      errors++; $display("FAIL rst_mid_values: got %h expected %h",
                         {out_valid, out_data, out_src, out_lr, out_first, overrun},
                         {1'b0, 4'h0, 2'd0, 1'b1, 1'b0, 4'h0});
    end
    out_ready = 1'b1;
    strobe(1, 1'b1, 4'd13);
    strobe(0, 1'b1, 4'd14);
    tick();
    src_en = '0;
    tick();
    checks++;
    if ({out_valid, out_src, out_data, out_first} !== {1'b1, 2'd0, 4'd14, 1'b1}) begin
      errors++; $display("FAIL rst_mid_first_grant: got %h expected %h",
                         {out_valid, out_src, out_data, out_first}, {1'b1, 2'd0, 4'd14, 1'b1});
    end
    tick(); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        src_en[i]   = ($urandom_range(0, 9) < 3);
        src_lr[i]   = $urandom_range(0, 1) == 1;
        src_mask[i] = ($urandom_range(0, 15) != 0);
        src_data[i*BP +: BP] = BP'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 6);
      ovr_clear = ($urandom_range(0, 9) == 0);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_cyc%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
    end
    src_en = '0; src_mask = '1; out_ready = 1'b1; ovr_clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_all_left();
    test_flip();
    test_stall();
    test_mask();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
